// File: rtl/orb_motion_if.sv
// orb_motion_if: frame-timing inputs and orb position/status outputs of the motion engine
interface orb_motion_if;
  logic       vsync;
  logic       pause;
  logic       boost;
  logic [9:0] orb1_x;
  logic [9:0] orb1_y;
  logic [9:0] orb2_x;
  logic [9:0] orb2_y;
  logic       update_done;
  logic [7:0] frame_count;
  modport master (output vsync, pause, boost,
                  input orb1_x, orb1_y, orb2_x, orb2_y, update_done, frame_count);
  modport slave (input vsync, pause, boost,
                 output orb1_x, orb1_y, orb2_x, orb2_y, update_done, frame_count);
endinterface

// File: rtl/orb_motion_ctrl.sv
// orb_motion_ctrl: steps two bouncing orbs once per frame through one shared add/clamp unit
module orb_motion_ctrl #(
  parameter int X_MIN = 10,
  parameter int X_MAX = 630,
  parameter int Y_MIN = 10,
  parameter int Y_MAX = 470,
  parameter int STEP1 = 2,
  parameter int STEP2 = 3
) (
  input logic        clk,
  input logic        reset,
  orb_motion_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UPD_X1, UPD_Y1, UPD_X2, UPD_Y2, DONE} state_t;
  state_t      state_q, state_d;
  logic        vsync_q, boost_q, ev, upd, at_lim;
  logic [7:0]  frame_q;
  logic [9:0]  pos_q [4];
  logic [3:0]  dir_q;
  logic [1:0]  sel;
  logic [10:0] pos, s, mn, mx, sum, dif;
  logic [9:0]  nxt;
  assign ev = vsync_q && !bus.vsync;
  // coordinate index 0..3 = x1, y1, x2, y2 follows the UPD_* encoding
  assign sel = 2'(state_q - 3'd1);
  assign upd = state_q inside {UPD_X1, UPD_Y1, UPD_X2, UPD_Y2};
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (ev && !bus.pause) ? UPD_X1 : IDLE;
    else state_d = (state_q == DONE) ? IDLE : state_t'(state_q + 3'd1);
  end
  always_comb begin
    pos = {1'b0, pos_q[sel]};
    mn = sel[0] ? 11'(Y_MIN) : 11'(X_MIN);
    mx = sel[0] ? 11'(Y_MAX) : 11'(X_MAX);
    s = (sel[1] ? 11'(STEP2) : 11'(STEP1)) << boost_q;
    sum = pos + s;
    dif = pos - s;
    at_lim = dir_q[sel] ? pos >= mx : pos <= mn;
    nxt = dir_q[sel] ? (sum >= mx ? mx[9:0] : sum[9:0]) : (pos >= mn + s ? dif[9:0] : mn[9:0]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b1;
      boost_q  <= 1'b0;
      frame_q  <= '0;
      pos_q[0] <= 10'd300;
      pos_q[1] <= 10'd200;
      pos_q[2] <= 10'd340;
      pos_q[3] <= 10'd280;
      dir_q    <= 4'b1011;
    end else begin
      state_q <= state_d;
      vsync_q <= bus.vsync;
      frame_q <= frame_q + 8'(ev);
      if (state_q == IDLE && ev) boost_q <= bus.boost;
      if (upd && at_lim) dir_q[sel] <= ~dir_q[sel];
      if (upd && !at_lim) pos_q[sel] <= nxt;
    end
  end
  assign bus.orb1_x      = pos_q[0];
  assign bus.orb1_y      = pos_q[1];
  assign bus.orb2_x      = pos_q[2];
  assign bus.orb2_y      = pos_q[3];
  assign bus.update_done = state_q == DONE;
  assign bus.frame_count = frame_q;
endmodule

// File: tb/tb_orb_motion_ctrl.sv
// tb_orb_motion_ctrl: directed frames with a scoreboard of hand-computed orb positions
module tb_orb_motion_ctrl;
  logic clk = 0, reset = 1;
  orb_motion_if bus ();
  orb_motion_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {string name; int x1, y1, x2, y2, fc;} exp_t;
  exp_t sb[$];
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0;
  logic prev_done = 0;
  task automatic chk(string n, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  task automatic push(string n, int x1, int y1, int x2, int y2, int fc);
    exp_t e;
    e.name = n; e.x1 = x1; e.y1 = y1; e.x2 = x2; e.y2 = y2; e.fc = fc;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (!reset && bus.update_done) begin
      done_cnt++;
      chk("done_width", int'(prev_done), 0);
      if (sb.size() > 0 && sb[0].fc == int'(bus.frame_count)) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_x1"}, int'(bus.orb1_x), e.x1);
        chk({e.name, "_y1"}, int'(bus.orb1_y), e.y1);
        chk({e.name, "_x2"}, int'(bus.orb2_x), e.x2);
        chk({e.name, "_y2"}, int'(bus.orb2_y), e.y2);
      end
    end
    prev_done = bus.update_done;
  end
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; bus.vsync = 1; bus.pause = 0; bus.boost = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic frame();
    @(posedge clk); #1 bus.vsync = 0;
    repeat (3) @(posedge clk);
    #1 bus.vsync = 1;
    repeat (4) @(posedge clk);
  endtask
  task automatic chk_reset_vals(string n);
    @(negedge clk);
    chk({n, "_x1"}, int'(bus.orb1_x), 300);
    chk({n, "_y1"}, int'(bus.orb1_y), 200);
    chk({n, "_x2"}, int'(bus.orb2_x), 340);
    chk({n, "_y2"}, int'(bus.orb2_y), 280);
    chk({n, "_fc"}, int'(bus.frame_count), 0);
    chk({n, "_done"}, int'(bus.update_done), 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    bus.vsync = 1; bus.pause = 0; bus.boost = 0;
    do_reset();
    chk_reset_vals("rst");
    push("basic", 302, 202, 337, 283, 1);
    frame();
    drain();
    do_reset();
    bus.boost = 1;
    push("boost", 304, 204, 334, 286, 1);
    frame();
    bus.boost = 0;
    drain();
    do_reset();
    d0 = done_cnt;
    bus.pause = 1;
    repeat (3) frame();
    bus.pause = 0;
    @(negedge clk);
    chk("pause_x1", int'(bus.orb1_x), 300);
    chk("pause_y2", int'(bus.orb2_y), 280);
    chk("pause_fc", int'(bus.frame_count), 3);
    chk("pause_done", done_cnt - d0, 0);
    do_reset();
    push("f64", 428, 328, 148, 470, 64);
    push("f65", 430, 330, 145, 470, 65);
    push("f66", 432, 332, 142, 467, 66);
    push("f165", 630, 412, 172, 170, 165);
    push("f166", 630, 410, 175, 167, 166);
    push("f167", 628, 408, 178, 164, 167);
    repeat (167) frame();
    chk("long_sb", sb.size(), 0);
    repeat (89) frame();
    @(negedge clk);
    chk("wrap_fc", int'(bus.frame_count), 0);
    do_reset();
    @(posedge clk); #1 bus.vsync = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1; bus.vsync = 1;
    @(posedge clk); #1 reset = 0;
    chk_reset_vals("midrst");
    push("after_rst", 302, 202, 337, 283, 1);
    frame();
    drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
